// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between producers, the arbiter and the sync_fifo_hd
// write port. master = arbiter view, slave = producers/FIFO view.
`timescale 1ns/1ps
interface fifo_wr_arbiter_if #(
  parameter int NREQ     = 2,
  parameter int DW       = 16,
  parameter int LEVLBITS = 5,
  parameter int IDBITS   = 3
);
  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0][DW-1:0]  req_data;   // requester i in [i]
  logic [NREQ-1:0]          req_ready;
  logic [LEVLBITS-1:0]      fifo_level;
  logic                     fifo_full;
  logic                     fifo_write;
  logic [DW-1:0]            fifo_wdata;
  logic [IDBITS-1:0]        grant_id;
  logic                     busy;

  modport master (
    input  req_valid, req_data, fifo_level, fifo_full,
    output req_ready, fifo_write, fifo_wdata, grant_id, busy
  );

  modport slave (
    output req_valid, req_data, fifo_level, fifo_full,
    input  req_ready, fifo_write, fifo_wdata, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers.
// Occupancy includes the registered write in flight, so the FIFO is never
// written while full. Optional macro ARB_BURST_EN: a winner keeps the grant
// for up to MAXBURST consecutive transfers (LOCK state + burst counter).
`timescale 1ns/1ps
module fifo_wr_arbiter #(
  parameter int NREQ     = 2,
  parameter int DW       = 16,
  parameter int DEPTH    = 16,
  parameter int LEVLBITS = 5,
  parameter int IDBITS   = 3,
  parameter int MAXBURST = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic clear,
  fifo_wr_arbiter_if.master bus
);

  if (NREQ < 2 || NREQ > 8 || IDBITS < $clog2(NREQ) || MAXBURST < 1 || MAXBURST > 16)
    $error("fifo_wr_arbiter: parameter out of range");

  typedef enum logic [0:0] {IDLE, LOCK} state_t;

  state_t              state_q, state_d;
  logic [IDBITS-1:0]   ptr_q, ptr_d, win_id, nxt_id, gid_q;
  logic [NREQ-1:0]     cand, win_oh, ready_c;
  logic                found, room, xfer;
  logic [LEVLBITS:0]   occ;
  logic [DW-1:0]       win_data, wdata_q;
  logic                write_q, busy_q;
`ifdef ARB_BURST_EN
  logic [4:0]          cnt_q, cnt_d;
  logic [IDBITS-1:0]   lock_nxt;
`endif

  function automatic logic [IDBITS-1:0] inc_mod(input logic [IDBITS-1:0] id);
    return (id == IDBITS'(NREQ-1)) ? '0 : id + IDBITS'(1);
  endfunction

  // Winner select, handshake and next-state (FSM, pointer, burst counter).
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
`ifdef ARB_BURST_EN
    cnt_d    = cnt_q;
    lock_nxt = inc_mod(gid_q);
    // While locked only the holder of the grant is a candidate.
    for (int i = 0; i < NREQ; i++)
      cand[i] = bus.req_valid[i] && (state_q != LOCK || IDBITS'(i) == gid_q);
`else
    cand = bus.req_valid;
`endif
    // First candidate at or above the pointer, then wrap to the bottom.
    found  = 1'b0;
    win_id = '0;
    for (int i = 0; i < NREQ; i++)
      if (!found && cand[i] && i >= int'(ptr_q)) begin
        found  = 1'b1;
        win_id = IDBITS'(i);
      end
    for (int i = 0; i < NREQ; i++)
      if (!found && cand[i]) begin
        found  = 1'b1;
        win_id = IDBITS'(i);
      end
    nxt_id   = inc_mod(win_id);
    win_oh   = '0;
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      win_oh[i] = found && (IDBITS'(i) == win_id);
      if (win_oh[i]) win_data = bus.req_data[i];
    end
    // Level lags the write strobe by a cycle, so count the one in flight.
    occ     = {1'b0, bus.fifo_level} + {{LEVLBITS{1'b0}}, write_q};
    room    = (occ < (LEVLBITS+1)'(DEPTH)) && !bus.fifo_full;
    xfer    = found && reset_n && enable && !clear && room;
    ready_c = xfer ? win_oh : '0;

    if (clear) begin
      state_d = IDLE;
      ptr_d   = '0;
`ifdef ARB_BURST_EN
      cnt_d   = '0;
`endif
    end else if (enable) begin
`ifdef ARB_BURST_EN
      case (state_q)
        IDLE:
          if (xfer) begin
            if (MAXBURST <= 1) ptr_d = nxt_id;
            else begin
              state_d = LOCK;
              cnt_d   = 5'd1;
            end
          end
        LOCK:
          if (!(|cand)) begin
            // Holder dropped valid: release and move past it.
            state_d = IDLE;
            ptr_d   = lock_nxt;
            cnt_d   = '0;
          end else if (xfer) begin
            if (cnt_q + 5'd1 >= 5'(MAXBURST)) begin
              state_d = IDLE;
              ptr_d   = nxt_id;
              cnt_d   = '0;
            end else cnt_d = cnt_q + 5'd1;
          end
        default: state_d = IDLE;
      endcase
`else
      case (state_q)
        IDLE:    if (xfer) ptr_d = nxt_id;
        default: state_d = IDLE;
      endcase
`endif
    end
  end

  // Arbitration state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
`ifdef ARB_BURST_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
`ifdef ARB_BURST_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Registered FIFO write port and back-pressure flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      write_q <= 1'b0;
      wdata_q <= '0;
      gid_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      write_q <= xfer;
      busy_q  <= (|bus.req_valid) && !xfer;
      if (xfer) begin
        wdata_q <= win_data;
        gid_q   <= win_id;
      end
    end
  end

  assign bus.req_ready  = ready_c;
  assign bus.fifo_write = write_q;
  assign bus.fifo_wdata = wdata_q;
  assign bus.grant_id   = gid_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a behavioural FIFO level model.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;
  logic clk, reset_n, enable, clear, fclr, rd;
  logic [4:0] level;
  int n_chk = 0, n_fail = 0;
  int n0, n1, e0, e1, wcnt, viol, w0;
  logic [15:0] last_exp;

  fifo_wr_arbiter_if #(.NREQ(2), .DW(16), .LEVLBITS(5), .IDBITS(3)) bus();

  fifo_wr_arbiter #(.NREQ(2), .DW(16), .DEPTH(16), .LEVLBITS(5), .IDBITS(3), .MAXBURST(4)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO occupancy model: +1 per write, -1 per read when non-empty.
  assign bus.fifo_level = level;
  assign bus.fifo_full  = (level == 5'd16);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) level <= '0;
    else if (fclr) level <= '0;
    else level <= level + {4'b0, bus.fifo_write} - {4'b0, (rd && level != 0)};
  end

  // Write counter and write-while-full detector.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wcnt <= 0;
      viol <= 0;
    end else begin
      if (bus.fifo_write) wcnt <= wcnt + 1;
      if (bus.fifo_write && bus.fifo_full) viol <= viol + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transfer expected from requester eid; producers count their own accepts.
  task automatic do_xfer(input string tag, input int eid);
    logic [1:0] hs;
    bus.req_data[0] = 16'h0100 + 16'(n0);
    bus.req_data[1] = 16'h0200 + 16'(n1);
    #1;
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'(2'b01 << eid));
    hs = bus.req_valid & bus.req_ready;
    step();
    n0 += int'(hs[0]);
    n1 += int'(hs[1]);
    if (eid == 0) begin last_exp = 16'h0100 + 16'(e0); e0++; end
    else          begin last_exp = 16'h0200 + 16'(e1); e1++; end
    chk({tag, "_write"}, 32'(bus.fifo_write), 32'd1);
    chk({tag, "_grant"}, 32'(bus.grant_id), 32'(eid));
    chk({tag, "_wdata"}, 32'(bus.fifo_wdata), 32'(last_exp));
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b1; clear = 1'b0; fclr = 1'b0; rd = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_data[0] = 16'h0100;
    bus.req_data[1] = 16'h0200;
    n0 = 0; n1 = 0; e0 = 0; e1 = 0; last_exp = '0;

    // Reset held with both requesters valid.
    for (int k = 0; k < 10; k++) begin
      step();
      chk("rst_write", 32'(bus.fifo_write), 32'd0);
      chk("rst_wdata", 32'(bus.fifo_wdata), 32'd0);
      chk("rst_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_grant", 32'(bus.grant_id), 32'd0);
      chk("rst_busy",  32'(bus.busy), 32'd0);
    end
    reset_n = 1'b1;
    rd = 1'b1;

    // Fairness stream with a draining sink.
    for (int k = 0; k < 8; k++) begin
`ifdef ARB_BURST_EN
      do_xfer("fair", (k / 4) % 2);
`else
      do_xfer("fair", k % 2);
`endif
    end

    // Enable gating for 5 cycles.
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("en_ready", 32'(bus.req_ready), 32'd0);
      step();
      chk("en_write", 32'(bus.fifo_write), 32'd0);
      chk("en_busy",  32'(bus.busy), 32'd1);
    end
    enable = 1'b1;
`ifdef ARB_BURST_EN
    do_xfer("resume", 0);
    do_xfer("resume", 0);
    do_xfer("resume", 0);
`else
    do_xfer("resume", 0);
    do_xfer("resume", 1);
    do_xfer("resume", 0);
`endif
    chk("resume_busy", 32'(bus.busy), 32'd0);

    // Clear mid-stream: write drops, data holds, next grant to requester 0.
    clear = 1'b1; fclr = 1'b1;
    #1;
    chk("clr_ready", 32'(bus.req_ready), 32'd0);
    step();
    clear = 1'b0; fclr = 1'b0;
    chk("clr_write", 32'(bus.fifo_write), 32'd0);
    chk("clr_wdata", 32'(bus.fifo_wdata), 32'(last_exp));
    chk("clr_busy",  32'(bus.busy), 32'd1);
    do_xfer("postclr", 0);
`ifdef ARB_BURST_EN
    // Holder drops valid after two transfers: grant passes to requester 1.
    do_xfer("drop", 0);
    bus.req_valid = 2'b10;
    #1;
    chk("drop_gap_ready", 32'(bus.req_ready), 32'd0);
    step();
    do_xfer("drop", 1);
`endif
    bus.req_valid = 2'b00;
    #1;
    chk("idle_ready", 32'(bus.req_ready), 32'd0);
    step();
    chk("idle_write", 32'(bus.fifo_write), 32'd0);
    chk("idle_busy",  32'(bus.busy), 32'd0);

    // Fill with no reads: exactly DEPTH writes, then blocked.
    clear = 1'b1; fclr = 1'b1; rd = 1'b0;
    step();
    clear = 1'b0; fclr = 1'b0;
    w0 = wcnt;
    bus.req_valid = 2'b01;
    for (int k = 0; k < 24; k++) step();
    chk("fill_count", 32'(wcnt - w0), 32'd16);
    chk("fill_ready", 32'(bus.req_ready), 32'd0);
    chk("fill_write", 32'(bus.fifo_write), 32'd0);
    chk("fill_grant", 32'(bus.grant_id), 32'd0);

    // One read frees one slot: exactly one more write.
    w0 = wcnt;
    rd = 1'b1;
    step();
    rd = 1'b0;
    for (int k = 0; k < 6; k++) step();
    chk("refill_count", 32'(wcnt - w0), 32'd1);
    chk("refill_ready", 32'(bus.req_ready), 32'd0);
    chk("no_write_full", 32'(viol), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Shares the single wide write port of a sync_fifo_hd instance between NREQ producers using valid/ready handshakes and round-robin arbitration. Tracks FIFO occupancy, including the write already in flight, so the FIFO is never written while full. Drives a registered write strobe and data straight into the FIFO's wdata/write inputs. Sits between producer blocks and the FIFO; the FIFO read side is untouched.

Parameters:
NREQ, 2, number of requesters (2..8)
DW, 16, write data width (= 2*WI of the FIFO)
DEPTH, 16, FIFO depth in write words as seen by fifo_level
LEVLBITS, 5, width of fifo_level; must hold 0..DEPTH
IDBITS, 3, width of grant_id; must be >= clog2(NREQ)
MAXBURST, 4, grant-lock length when ARB_BURST_EN is defined (1..16)

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
enable  in  1  0 = freeze: no grants, state held
clear  in  1  synchronous flush of arbiter state (pulse together with FIFO clear)
req_valid  in  NREQ  per-requester data valid
req_data  in  NREQ*DW  requester i data in bits [i*DW +: DW]
req_ready  out  NREQ  per-requester accept, one-hot or zero
fifo_level  in  LEVLBITS  FIFO level output
fifo_full  in  1  FIFO full flag
fifo_write  out  1  registered write strobe to FIFO
fifo_wdata  out  DW  registered write data to FIFO
grant_id  out  IDBITS  index of the requester behind the current fifo_write
busy  out  1  1 while any req_valid is pending and none is accepted (back-pressure)

Behaviour:
- Reset: fifo_write=0, fifo_wdata=0, grant_id=0, busy=0, RR pointer=0, burst counter=0, FSM=IDLE.
- room = (fifo_level + fifo_write) < DEPTH && !fifo_full. Compute the sum LEVLBITS+1 wide. The registered write is counted because level updates one cycle after write.
- Winner: first asserted req_valid at or after the RR pointer, scanning upward mod NREQ.
- req_ready[winner] = enable && !clear && room. This path is combinational from req_valid, fifo_level and fifo_full. All other bits of req_ready are 0.
- Transfer when req_valid[i] && req_ready[i]. On the next edge: fifo_write=1, fifo_wdata=req_data[i], grant_id=i, RR pointer=(i+1) mod NREQ.
- Latency: handshake cycle to fifo_write high is 1 cycle. Back-to-back transfers every cycle while room holds.
- No transfer in a cycle: fifo_write goes to 0 next edge. fifo_wdata and grant_id hold.
- busy = |req_valid && !(|req_ready) (registered, 1-cycle lag).
- enable=0: req_ready=0, fifo_write goes to 0, pointer, counter and FSM hold.
- clear=1 (priority over enable): req_ready=0, fifo_write goes to 0, pointer=0, counter=0, FSM=IDLE. fifo_wdata holds.
- A single requester with continuous valid is granted every cycle; the pointer wraps naturally.
- Reset asserted mid-transfer: all state returns to reset values immediately (asynchronous); the pending write is dropped.
- FSM (meaningful only with ARB_BURST_EN; without the macro it stays in IDLE):
  - IDLE: winner chosen per cycle.
  - IDLE -> LOCK on a transfer, with the counter set to 1.
  - LOCK: only the locked id may be granted. The counter increments on each transfer.
  - LOCK -> IDLE when the counter reaches MAXBURST, or when the locked requester drops valid, or on clear.

Optional Feature:
ARB_BURST_EN:
- Defined: a granted requester keeps the grant for up to MAXBURST consecutive transfers, for burst-contiguous data. The RR pointer advances only on LOCK -> IDLE. A stall from no room keeps LOCK and the counter.
- Not defined: pure per-transfer round-robin; LOCK logic and the counter are not built.

Test Plan:
- Reset: assert reset_n=0 for 10 cycles with req_valid=2'b11 -> fifo_write=0, fifo_wdata=0, req_ready=0, grant_id=0, busy=0 throughout.
- Fairness: req_valid=2'b11 constant, sink reads continuously, data 0x0100+n / 0x0200+n -> grant_id alternates 0,1,0,1…; fifo_wdata stream matches the per-requester counters in order.
- Fill: no FIFO reads, req_valid=2'b01 -> exactly 16 writes, then req_ready=0. No fifo_write while fifo_full=1. A read pulse then allows exactly one more write.
- Clear: clear pulse during a stream with the pointer at 1 -> fifo_write=0 on the next cycle; the next grant with both valid goes to requester 0.
- Enable gating: enable=0 for 5 cycles mid-stream -> no writes, busy=1 after 1 cycle; resumes with the same RR order.
- ARB_BURST_EN, MAXBURST=4, both valid -> grant_id 0,0,0,0,1,1,1,1. Dropping req_valid[0] after 2 transfers hands the grant to 1 on the next transfer.
